// File: rtl/vu_meter_scheduler.sv
// Serialises parallel audio frames into the channel-multiplexed
// sample stream feeding vu_meter, with inter-word gaps and sync.
module vu_meter_scheduler #(
  parameter int NR_CHANNELS = 3,
  parameter int INPUT_WIDTH = 24,
  parameter int SYNC_FRAMES = 3,
  parameter int GAP         = 1,
  localparam int CHW = (NR_CHANNELS < 2) ? 1 : $clog2(NR_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               mute,
  input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_frame_d,
  input  logic                               s_frame_dv,
  output logic                               s_frame_rdy,
  output logic [INPUT_WIDTH-1:0]             vm_signal_d,
  output logic [CHW-1:0]                     vm_signal_ch,
  output logic                               vm_signal_dv,
  output logic                               vm_sync,
  output logic                               frame_overrun
);

  localparam int FW = (SYNC_FRAMES < 2) ? 1 : $clog2(SYNC_FRAMES);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NR_CHANNELS - 1);
  localparam logic [FW-1:0]  FC_LAST  = FW'(SYNC_FRAMES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_SYNC
  } state_t;

  state_t state_q, state_d;

  logic [CHW-1:0] ch_q, ch_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [FW-1:0]  fc_q, fc_d;
  logic [NR_CHANNELS*INPUT_WIDTH-1:0] frame_q;
  logic mute_q;

  logic                               accept;
  logic                               load;
  logic [NR_CHANNELS*INPUT_WIDTH-1:0] src;
  logic                               src_mute;
  logic [INPUT_WIDTH-1:0]             sample;

  assign accept = s_frame_dv && s_frame_rdy;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    fc_d    = fc_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND;
          ch_d    = '0;
          load    = 1'b1;
        end else if (!enable) begin
          fc_d = '0;
        end
      end
      S_SEND: begin
        unique case (1'b1)
          (ch_q != CH_LAST): begin
            ch_d    = ch_q + 1'b1;
            gap_d   = '0;
            state_d = (GAP > 0) ? S_GAP : S_SEND;
          end
          (ch_q == CH_LAST && fc_q == FC_LAST): begin
            fc_d    = '0;
            state_d = S_SYNC;
          end
          default: begin
            fc_d    = fc_q + 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_SEND;
        else gap_d = gap_q + 1'b1;
      end
      S_SYNC: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // first word of a frame comes straight from the port being accepted
  always_comb begin
    src      = load ? s_frame_d : frame_q;
    src_mute = load ? mute : mute_q;
    sample   = src[int'(ch_d)*INPUT_WIDTH +: INPUT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      gap_q         <= '0;
      fc_q          <= '0;
      frame_q       <= '0;
      mute_q        <= 1'b0;
      s_frame_rdy   <= 1'b0;
      vm_signal_d   <= '0;
      vm_signal_ch  <= '0;
      vm_signal_dv  <= 1'b0;
      vm_sync       <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      gap_q         <= gap_d;
      fc_q          <= fc_d;
      s_frame_rdy   <= (state_d == S_IDLE) && enable;
      vm_signal_dv  <= (state_d == S_SEND);
      vm_sync       <= (state_d == S_SYNC);
      frame_overrun <= s_frame_dv && !s_frame_rdy;
      if (load) begin
        frame_q <= s_frame_d;
        mute_q  <= mute;
      end
      if (state_d == S_SEND) begin
        vm_signal_d  <= src_mute ? '0 : sample;
        vm_signal_ch <= ch_d;
      end
    end
  end

endmodule

// File: tb/tb_vu_meter_scheduler.sv
// Randomised and directed bench for vu_meter_scheduler against
// a schedule-based reference model.
module tb_vu_meter_scheduler;

  localparam int N     = 3;
  localparam int W     = 24;
  localparam int SF    = 3;
  localparam int G     = 1;
  localparam int CHW   = 2;
  localparam int STEP  = G + 1;
  localparam int LASTO = (N - 1) * STEP;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           mute;
  logic [N*W-1:0] s_frame_d;
  logic           s_frame_dv;
  logic           s_frame_rdy;
  logic [W-1:0]   vm_signal_d;
  logic [CHW-1:0] vm_signal_ch;
  logic           vm_signal_dv;
  logic           vm_sync;
  logic           frame_overrun;

  vu_meter_scheduler #(
    .NR_CHANNELS(N),
    .INPUT_WIDTH(W),
    .SYNC_FRAMES(SF),
    .GAP(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .mute(mute),
    .s_frame_d(s_frame_d),
    .s_frame_dv(s_frame_dv),
    .s_frame_rdy(s_frame_rdy),
    .vm_signal_d(vm_signal_d),
    .vm_signal_ch(vm_signal_ch),
    .vm_signal_dv(vm_signal_dv),
    .vm_sync(vm_sync),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;
  int free_at;
  int fc;
  bit m_rdy;
  bit m_ovr;
  logic [W-1:0] last_d;
  int last_ch;
  int syncs_seen;
  int ovr_seen;

  logic [W-1:0] exp_d[int];
  int           exp_ch[int];
  bit           exp_sync[int];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_d.delete();
    exp_ch.delete();
    exp_sync.delete();
    free_at = 0;
    fc      = 0;
    m_rdy   = 0;
    m_ovr   = 0;
    last_d  = '0;
    last_ch = 0;
  endtask

  // Schedule a whole frame's outputs at acceptance time
  task automatic model_edge();
    int u;
    bit acc;
    cyc++;
    u     = cyc;
    acc   = s_frame_dv && m_rdy;
    m_ovr = s_frame_dv && !m_rdy;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        exp_d[u + k*STEP]  = mute ? '0 : s_frame_d[k*W +: W];
        exp_ch[u + k*STEP] = k;
      end
      fc++;
      if (fc == SF) begin
        fc = 0;
        exp_sync[u + LASTO + 1] = 1'b1;
        free_at = u + LASTO + 2;
      end else begin
        free_at = u + LASTO + 1;
      end
    end else if (u - 1 >= free_at && !enable) begin
      fc = 0;
    end
    m_rdy = (u >= free_at) && enable;
  endtask

  task automatic check_out();
    bit dv;
    dv = exp_d.exists(cyc);
    if (dv) begin
      last_d  = exp_d[cyc];
      last_ch = exp_ch[cyc];
    end
    if (vm_sync === 1'b1) syncs_seen++;
    if (frame_overrun === 1'b1) ovr_seen++;
    chk("dv", vm_signal_dv, dv);
    chk("data", vm_signal_d, last_d);
    chk("ch", vm_signal_ch, last_ch);
    chk("sync", vm_sync, exp_sync.exists(cyc));
    chk("rdy", s_frame_rdy, m_rdy);
    chk("overrun", frame_overrun, m_ovr);
  endtask

  task automatic check_zero();
    chk("rst_dv", vm_signal_dv, 0);
    chk("rst_data", vm_signal_d, 0);
    chk("rst_ch", vm_signal_ch, 0);
    chk("rst_sync", vm_sync, 0);
    chk("rst_rdy", s_frame_rdy, 0);
    chk("rst_overrun", frame_overrun, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else cyc++;
    @(negedge clk);
    if (rst_n) check_out();
    else check_zero();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at a falling edge; reset lands mid-cycle
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_zero();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
    return f;
  endfunction

  task automatic offer(logic [N*W-1:0] f, bit mu);
    int w;
    w = 0;
    while (!m_rdy && w < 60) begin
      tick();
      w++;
    end
    if (!m_rdy) chk("offer_timeout", m_rdy, 1);
    s_frame_d  = f;
    mute       = mu;
    s_frame_dv = 1'b1;
    tick();
    s_frame_dv = 1'b0;
  endtask

  task automatic clear_frames();
    enable = 1'b0;
    ticks(2);
    enable = 1'b1;
    tick();
  endtask

  initial begin
    int s0;
    int o0;
    logic [N*W-1:0] f;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    syncs_seen = 0;
    ovr_seen = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    mute = 1'b0;
    s_frame_d = '0;
    s_frame_dv = 1'b0;
    model_reset();

    ticks(2);
    rst_n = 1'b1;
    tick();

    f = {24'h300003, 24'h200002, 24'h100001};
    offer(f, 1'b0);
    ticks(8);

    clear_frames();
    s0 = syncs_seen;
    for (int i = 0; i < 6; i++) offer(rand_frame(), 1'b0);
    ticks(8);
    chk("sync_count_6", syncs_seen - s0, 2);

    offer(rand_frame(), 1'b1);
    mute = 1'b0;
    ticks(7);
    offer(rand_frame(), 1'b0);
    mute = 1'b1;
    ticks(7);
    mute = 1'b0;

    offer(rand_frame(), 1'b0);
    tick();
    o0 = ovr_seen;
    s_frame_d  = rand_frame();
    s_frame_dv = 1'b1;
    tick();
    s_frame_dv = 1'b0;
    ticks(8);
    chk("overrun_count", ovr_seen - o0, 1);

    clear_frames();
    offer(rand_frame(), 1'b0);
    offer(rand_frame(), 1'b0);
    ticks(2);
    async_reset();
    s0 = syncs_seen;
    for (int i = 0; i < 3; i++) offer(rand_frame(), 1'b0);
    ticks(8);
    chk("sync_after_reset", syncs_seen - s0, 1);

    offer(rand_frame(), 1'b0);
    tick();
    enable = 1'b0;
    ticks(12);
    enable = 1'b1;
    ticks(3);

    for (int i = 0; i < 900; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      mute       = ($urandom_range(0, 3) == 0);
      s_frame_dv = ($urandom_range(0, 2) == 0);
      s_frame_d  = rand_frame();
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    s_frame_dv = 1'b0;
    enable = 1'b1;
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vu_meter_scheduler.md
Name: vu_meter_scheduler

Overview:
- Sequences parallel multi-channel audio frames into the channel-multiplexed sample stream that feeds vu_meter: data, channel index, data-valid and the periodic sync pulse.
- Accepts one frame of NR_CHANNELS samples per valid/ready handshake and serialises the channels in ascending order, with a programmable idle gap between words.
- Issues vm_sync once every SYNC_FRAMES frames, and applies mute.
- Sits between the audio source (I2S/mixer) and vu_meter.

Parameters:
- NR_CHANNELS, 3, channels per frame (>=1)
- INPUT_WIDTH, 24, sample width in bits
- SYNC_FRAMES, 3, frames between vm_sync pulses (>=1)
- GAP, 1, idle cycles between consecutive channel words (>=0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable
- mute  in  1  zero outgoing samples; sampled at frame acceptance
- s_frame_d  in  NR_CHANNELS*INPUT_WIDTH  frame; channel k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- s_frame_dv  in  1  frame valid
- s_frame_rdy  out  1  frame ready
- vm_signal_d  out  INPUT_WIDTH  sample to vu_meter
- vm_signal_ch  out  CHW  channel index; CHW = 1 if NR_CHANNELS<2, else clog2(NR_CHANNELS)
- vm_signal_dv  out  1  sample valid, one-cycle pulse
- vm_sync  out  1  level window sync, one-cycle pulse
- frame_overrun  out  1  one-cycle pulse when a frame is offered and not accepted

Behaviour:
- Reset:
  - rst_n low clears all outputs and state asynchronously.
  - State goes to IDLE; channel counter, gap counter and frame counter go to 0.
  - All outputs are registered and read 0 during reset.
- States are IDLE, SEND, GAP and SYNC.
- IDLE:
  - s_frame_rdy = enable.
  - On a clock edge where s_frame_dv && s_frame_rdy, latch s_frame_d and the mute flag (mute_l), set ch=0, go to SEND.
  - If enable is low, the frame counter is cleared.
- SEND (one cycle per channel):
  - vm_signal_dv=1, vm_signal_ch=ch, vm_signal_d = mute_l ? 0 : sample[ch].
  - If ch<NR_CHANNELS-1: ch++, then go to GAP when GAP>0, else stay in SEND.
  - If ch==NR_CHANNELS-1 and frame_cnt==SYNC_FRAMES-1: frame_cnt=0, go to SYNC.
  - If ch==NR_CHANNELS-1 otherwise: frame_cnt++, go to IDLE.
- GAP:
  - vm_signal_dv=0; vm_signal_d and vm_signal_ch hold their last values.
  - Count GAP cycles, then go to SEND.
- SYNC: vm_sync=1 for exactly one cycle, vm_signal_dv=0, then go to IDLE.
- Latency, with acceptance at edge E0:
  - Channel k dv is high in cycle 1 + k*(GAP+1) after E0.
  - vm_sync is high in the cycle immediately after the last channel's dv.
  - s_frame_rdy returns high the cycle after the last dv, or the cycle after vm_sync.
  - Frame period = NR_CHANNELS + (NR_CHANNELS-1)*GAP + 1, plus 1 cycle on sync frames.
- Handshake:
  - s_frame_rdy is low in SEND, GAP and SYNC, and while enable=0.
  - s_frame_dv high while s_frame_rdy is low raises frame_overrun for that cycle; the frame is dropped.
  - Outputs to vu_meter are unaffected by a dropped frame.
  - The source is not required to hold s_frame_dv.
- Mute and enable:
  - mute changes mid-frame have no effect on the frame in flight.
  - Deasserting enable mid-frame completes the current frame, including a due sync, then stays in IDLE with rdy=0.
- The channel counter never exceeds NR_CHANNELS-1; the frame counter wraps at SYNC_FRAMES.
- With SYNC_FRAMES=1, every frame ends with a sync.
- With NR_CHANNELS=1, one dv is issued per frame with ch=0.

Test Plan:
- Reset and idle (defaults):
  - With rst_n low, all outputs are 0.
  - Release with enable=1: s_frame_rdy=1 the next cycle.
  - Drop rst_n mid-cycle: outputs clear without waiting for a clock edge.
- Single frame, GAP=1:
  - Offer {0x300003, 0x200002, 0x100001}.
  - dv is high in cycles 1, 3 and 5 after acceptance, with ch 0/1/2 and data 0x100001/0x200002/0x300003.
  - Data and channel hold during gap cycles 2 and 4.
  - No sync; rdy is high again in cycle 6.
- Sync cadence:
  - Offer 6 back-to-back frames.
  - vm_sync pulses exactly once after frame 3 ch2 and once after frame 6 ch2.
  - Each pulse lands in the cycle following ch2's dv; there is no dv in that cycle.
- Mute:
  - mute=1 at acceptance: three dv pulses with d=0 and ch 0/1/2.
  - mute=0 at acceptance, then raised after ch0: all three samples pass unmodified.
- Overrun:
  - Pulse s_frame_dv during GAP of a frame in flight.
  - frame_overrun is high for 1 cycle; the dropped frame's data never appears.
  - The in-flight frame's sequence and sync count are unchanged.
- Reset mid-operation and enable:
  - Assert rst_n low after frame 2 ch1: dv stops immediately.
  - After release, the next sync comes after 3 full frames.
  - enable=0 during a frame's GAP: the frame completes and rdy stays 0 until enable=1.
